// File: rtl/plotter_pkg.sv
// Shared types and screen constants for the square plotter.
package plotter_pkg;

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  localparam int unsigned SCREEN_X_MAX = 159;
  localparam int unsigned SCREEN_Y_MAX = 119;

  localparam logic [CW-1:0] BG_DEFAULT = 3'b000;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_e;

endpackage

// File: rtl/pixel_scan_counter.sv
// Raster dx/dy counter over a SIZE x SIZE square; exposes next values so the
// owner can register pixel outputs in the same cycle the count changes.
module pixel_scan_counter #(
  parameter int unsigned SIZE = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  output logic [3:0] dx_next,
  output logic [3:0] dy_next,
  output logic       last
);

  localparam logic [3:0] LastIdx = 4'(SIZE - 1);

  logic [3:0] dx_q, dy_q;

  always_comb begin
    dx_next = dx_q;
    dy_next = dy_q;
    if (clear) begin
      dx_next = '0;
      dy_next = '0;
    end else if (advance) begin
      if (dx_q == LastIdx) begin
        dx_next = '0;
        dy_next = (dy_q == LastIdx) ? 4'd0 : dy_q + 4'd1;
      end else begin
        dx_next = dx_q + 4'd1;
      end
    end
  end

  assign last = (dx_q == LastIdx) && (dy_q == LastIdx);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_q <= '0;
      dy_q <= '0;
    end else begin
      dx_q <= dx_next;
      dy_q <= dy_next;
    end
  end

endmodule

// File: rtl/square_plotter.sv
// Serialises square draw requests (with optional erase of the previous square)
// into one registered framebuffer write per clock.
module square_plotter import plotter_pkg::*; #(
  parameter int unsigned    SIZE      = 4,
  parameter int unsigned    X_MAX     = SCREEN_X_MAX,
  parameter int unsigned    Y_MAX     = SCREEN_Y_MAX,
  parameter logic [CW-1:0]  BG_COLOUR = BG_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req,
  input  logic [XW-1:0] req_x,
  input  logic [YW-1:0] req_y,
  input  logic [CW-1:0] req_colour,
  input  logic          erase_en,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] colour,
  output logic          plot
);

  state_e state_q, state_d;

  logic [XW-1:0] lat_x_q, prev_x_q, x_q, org_x;
  logic [YW-1:0] lat_y_q, prev_y_q, y_q, org_y;
  logic [CW-1:0] lat_c_q, colour_q, col_d;
  logic          prev_valid_q, plot_q, busy_q, done_q;
  logic          clear, advance, last, accept, pixel_on, in_range;
  logic [3:0]    dx_next, dy_next;
  logic [XW:0]   sum_x;
  logic [YW:0]   sum_y;

  assign accept = (state_q == IDLE) && req;

  pixel_scan_counter #(
    .SIZE (SIZE)
  ) u_scan (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .advance (advance),
    .dx_next (dx_next),
    .dy_next (dy_next),
    .last    (last)
  );

  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = (erase_en && prev_valid_q) ? ERASE : DRAW;
          clear   = 1'b1;
        end
      end
      ERASE: begin
        if (last) begin
          state_d = DRAW;
          clear   = 1'b1;
        end else begin
          advance = 1'b1;
        end
      end
      DRAW: begin
        if (last) state_d = DONE;
        else      advance = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state/count so the first pixel
  // appears the cycle right after acceptance.
  always_comb begin
    org_x = accept ? req_x : lat_x_q;
    org_y = accept ? req_y : lat_y_q;
    col_d = accept ? req_colour : lat_c_q;
    if (state_d == ERASE) begin
      org_x = prev_x_q;
      org_y = prev_y_q;
      col_d = BG_COLOUR;
    end
  end

  assign sum_x    = {1'b0, org_x} + {5'b0, dx_next};
  assign sum_y    = {1'b0, org_y} + {4'b0, dy_next};
  assign in_range = (sum_x <= (XW+1)'(X_MAX)) && (sum_y <= (YW+1)'(Y_MAX));
  assign pixel_on = (state_d == ERASE) || (state_d == DRAW);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_x_q      <= '0;
      lat_y_q      <= '0;
      lat_c_q      <= '0;
      prev_x_q     <= '0;
      prev_y_q     <= '0;
      prev_valid_q <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      colour_q     <= '0;
      plot_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        lat_x_q <= req_x;
        lat_y_q <= req_y;
        lat_c_q <= req_colour;
      end
      if (state_q == DONE) begin
        prev_x_q     <= lat_x_q;
        prev_y_q     <= lat_y_q;
        prev_valid_q <= 1'b1;
      end
      if (pixel_on) begin
        x_q      <= sum_x[XW-1:0];
        y_q      <= sum_y[YW-1:0];
        colour_q <= col_d;
        plot_q   <= in_range;
      end else begin
        plot_q   <= 1'b0;
      end
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
    end
  end

  assign x      = x_q;
  assign y      = y_q;
  assign colour = colour_q;
  assign plot   = plot_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_square_plotter.sv
// Directed self-checking bench for square_plotter (SIZE=4, 160x120 screen).
module tb_square_plotter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [7:0] req_x = '0;
  logic [6:0] req_y = '0;
  logic [2:0] req_colour = '0;
  logic       erase_en = 1'b0;
  logic       busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  int checks = 0;
  int errors = 0;

  square_plotter dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_colour (req_colour),
    .erase_en   (erase_en),
    .busy       (busy),
    .done       (done),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive a request across one rising edge; returns at the first pass cycle.
  task automatic do_req(input int rx, input int ry, input int rc, input bit re);
    req        = 1'b1;
    req_x      = 8'(rx);
    req_y      = 7'(ry);
    req_colour = 3'(rc);
    erase_en   = re;
    @(negedge clock);
    req = 1'b0;
  endtask

  // Check one full SIZE x SIZE raster pass, one pixel per cycle.
  task automatic check_pass(input int ox, input int oy, input int col, input bit scramble);
    for (int dy = 0; dy < 4; dy++) begin
      for (int dx = 0; dx < 4; dx++) begin
        int ex = ox + dx;
        int ey = oy + dy;
        bit vis = (ex <= 159) && (ey <= 119);
        check("plot", {31'b0, plot}, {31'b0, vis});
        if (vis) begin
          check("x", {24'b0, x}, ex);
          check("y", {25'b0, y}, ey);
          check("colour", {29'b0, colour}, col);
        end
        check("busy_pass", {31'b0, busy}, 1);
        check("done_pass", {31'b0, done}, 0);
        if (scramble) begin
          req_x = 8'($urandom_range(0, 150));
          req_y = 7'($urandom_range(0, 110));
          req_colour = 3'($urandom_range(0, 7));
        end
        @(negedge clock);
      end
    end
  endtask

  task automatic check_done();
    check("done_pulse", {31'b0, done}, 1);
    check("busy_done", {31'b0, busy}, 1);
    check("plot_done", {31'b0, plot}, 0);
    @(negedge clock);
    check("busy_after", {31'b0, busy}, 0);
    check("done_after", {31'b0, done}, 0);
    check("plot_after", {31'b0, plot}, 0);
  endtask

  initial begin
    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_x", {24'b0, x}, 0);
    check("rst_y", {25'b0, y}, 0);
    check("rst_colour", {29'b0, colour}, 0);
    check("rst_plot", {31'b0, plot}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    reset = 1'b0;
    @(negedge clock);
    check("idle_plot", {31'b0, plot}, 0);

    // First draw: erase requested but nothing drawn yet
    do_req(10, 20, 3'b100, 1'b1);
    check_pass(10, 20, 3'b100, 1'b0);
    check_done();

    // Move right by one with erase
    do_req(11, 20, 3'b100, 1'b1);
    check_pass(10, 20, 3'b000, 1'b0);
    check_pass(11, 20, 3'b100, 1'b0);
    check_done();

    // Bottom-right corner clipping
    do_req(158, 118, 3'b010, 1'b0);
    check_pass(158, 118, 3'b010, 1'b0);
    check_done();

    // Held req with changing inputs is ignored while busy
    do_req(30, 40, 3'b001, 1'b0);
    req = 1'b1;
    check_pass(30, 40, 3'b001, 1'b1);
    req_x = 8'd60;
    req_y = 7'd50;
    req_colour = 3'b101;
    check_done();
    @(negedge clock);
    req = 1'b0;
    check_pass(60, 50, 3'b101, 1'b0);
    check_done();

    // Asynchronous reset on the fifth draw pixel
    do_req(5, 5, 3'b011, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clock);
    check("pix5_plot", {31'b0, plot}, 1);
    check("pix5_x", {24'b0, x}, 5);
    check("pix5_y", {25'b0, y}, 6);
    #2 reset = 1'b1;
    #1;
    check("arst_plot", {31'b0, plot}, 0);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("no_done_after_rst", {31'b0, done}, 0);
      check("no_busy_after_rst", {31'b0, busy}, 0);
    end

    // prev_valid cleared by reset: erase request draws directly
    do_req(20, 30, 3'b110, 1'b1);
    check_pass(20, 30, 3'b110, 1'b0);
    check_done();

    // Second draw without erase
    do_req(40, 60, 3'b111, 1'b0);
    check_pass(40, 60, 3'b111, 1'b0);
    check_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
